andarb_sched: RTL and testbench



---
 rtl/andarb_pkg.sv | 13 +
 rtl/andarb_rr_pick.sv | 40 ++++
 rtl/andarb_sched.sv | 100 ++++++++++
 tb/tb_andarb_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/andarb_pkg.sv
// Shared definitions for the round-robin AND scheduler: FSM encoding and
// stall-counter sizing.
package andarb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int                BUSY_W   = 16;
  localparam logic [BUSY_W-1:0] BUSY_SAT = {BUSY_W{1'b1}};

endpackage

// File: rtl/andarb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Produces one-hot grant, binary index and an any flag.
module andarb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0]  cand_idx [NREQ];
  logic [NREQ-1:0] rot_req;

  // rot_req[gi] is the request seen gi positions after ptr
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IDW:0] sum;
    assign sum          = {1'b0, ptr} + (IDW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                  : sum[IDW-1:0];
    assign rot_req[gi]  = en & req[cand_idx[gi]];
  end

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && rot_req[i]) begin
        any = 1'b1;
        idx = cand_idx[i];
      end
    end
  end

  assign grant = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/andarb_sched.sv
// Round-robin scheduler sharing one W-bit AND datapath among NREQ requesters,
// with a one-entry output register that can drain and refill in one cycle.
module andarb_sched
  import andarb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_o,
  output logic [IDW-1:0]    out_id,
  output logic [BUSY_W-1:0] busy_cnt
);

  state_t              state_reg, state_next;
  logic [IDW-1:0]      ptr_reg, ptr_next;
  logic [W-1:0]        out_o_reg;
  logic [IDW-1:0]      out_id_reg;
  logic [BUSY_W-1:0]   busy_cnt_reg;

  logic                can_accept;
  logic                pick_en;
  logic [NREQ-1:0]     pick_grant;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic                xfer;
  logic                stall;
  logic [W-1:0]        and_res [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_and
    assign and_res[gi] = req_a[gi*W +: W] & req_b[gi*W +: W];
  end

  assign can_accept = (state_reg == ST_EMPTY) || out_ready;
  // Holding off grants while rst_n is low keeps a pending requester waiting
  assign pick_en    = can_accept & rst_n;

  andarb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .en    (pick_en),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = pick_grant;
  assign xfer      = |(req_valid & pick_grant);
  assign stall     = (state_reg == ST_FULL) && !out_ready;
  assign ptr_next  = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (xfer) state_next = ST_FULL;
      ST_FULL: begin
        if (xfer)           state_next = ST_FULL;
        else if (out_ready) state_next = ST_EMPTY;
      end
      default:              state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      ptr_reg      <= '0;
      out_o_reg    <= '0;
      out_id_reg   <= '0;
      busy_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (xfer) begin
        out_o_reg  <= and_res[pick_idx];
        out_id_reg <= pick_idx;
        ptr_reg    <= ptr_next;
      end
      if (stall && (busy_cnt_reg != BUSY_SAT)) begin
        busy_cnt_reg <= busy_cnt_reg + 1'b1;
      end
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_o     = out_o_reg;
  assign out_id    = out_id_reg;
  assign busy_cnt  = busy_cnt_reg;

endmodule

// File: tb/tb_andarb_sched.sv
// Directed bench for andarb_sched: a vector table for grant/result behaviour,
// plus hand sequences for backpressure, mid-stream reset and counter saturation.
module tb_andarb_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_o;
  logic [1:0]  out_id;
  logic [15:0] busy_cnt;

  int checks = 0;
  int errors = 0;

  andarb_sched #(
    .NREQ (4),
    .W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_o     (out_o),
    .out_id    (out_id),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] rv;
    logic [7:0] a;
    logic [7:0] b;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_v;
    logic [1:0] e_o;
    logic [1:0] e_id;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge: drive, check grant mid-cycle, then check the
  // registered result #1 after the next posedge.
  task automatic step(input string tag, input logic [3:0] rv, input logic [7:0] a,
                      input logic [7:0] b, input logic ordy, input logic [3:0] e_rdy,
                      input logic e_v, input logic [1:0] e_o, input logic [1:0] e_id);
    req_valid = rv;
    req_a     = a;
    req_b     = b;
    out_ready = ordy;
    #4;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_v));
    if (e_v) begin
      chk({tag, ".out_o"}, 32'(out_o), 32'(e_o));
      chk({tag, ".out_id"}, 32'(out_id), 32'(e_id));
    end
    $display("%s rv=%b ordy=%b rdy=%b v=%b o=%b id=%0d busy=%0d",
             tag, rv, ordy, req_ready, out_valid, out_o, out_id, busy_cnt);
  endtask

  initial begin
    // single requester, idle drain, skip/wrap, then round-robin with ptr=1
    tbl[0]  = '{4'b0100, 8'h30, 8'h20, 1'b1, 4'b0100, 1'b1, 2'b10, 2'd2};
    tbl[1]  = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 2'b00, 2'd0};
    tbl[2]  = '{4'b0010, 8'h0C, 8'h04, 1'b1, 4'b0010, 1'b1, 2'b01, 2'd1};
    tbl[3]  = '{4'b1001, 8'h83, 8'hC3, 1'b1, 4'b1000, 1'b1, 2'b10, 2'd3};
    tbl[4]  = '{4'b1001, 8'h83, 8'hC3, 1'b1, 4'b0001, 1'b1, 2'b11, 2'd0};
    tbl[5]  = '{4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b0010, 1'b1, 2'b01, 2'd1};
    tbl[6]  = '{4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b0100, 1'b1, 2'b10, 2'd2};
    tbl[7]  = '{4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b1000, 1'b1, 2'b11, 2'd3};
    tbl[8]  = '{4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b0001, 1'b1, 2'b00, 2'd0};
    tbl[9]  = '{4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b0010, 1'b1, 2'b01, 2'd1};
    tbl[10] = '{4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b0100, 1'b1, 2'b10, 2'd2};
    tbl[11] = '{4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b1000, 1'b1, 2'b11, 2'd3};
    tbl[12] = '{4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b0001, 1'b1, 2'b00, 2'd0};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = 8'hFF;
    req_b     = 8'hFF;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_o", 32'(out_o), 32'd0);
    chk("rst.out_id", 32'(out_id), 32'd0);
    chk("rst.busy_cnt", 32'(busy_cnt), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    rst_n     = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), tbl[i].rv, tbl[i].a, tbl[i].b, tbl[i].ordy,
           tbl[i].e_rdy, tbl[i].e_v, tbl[i].e_o, tbl[i].e_id);
    end
    chk("rr.busy_cnt", 32'(busy_cnt), 32'd0);

    // backpressure: result and id held, no grants, stalls counted
    for (int i = 0; i < 5; i++) begin
      step($sformatf("stall%0d", i), 4'b1111, 8'hE4, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'b00, 2'd0);
    end
    chk("stall.busy_cnt", 32'(busy_cnt), 32'd5);
    step("release", 4'b1111, 8'hE4, 8'hFF, 1'b1, 4'b0010, 1'b1, 2'b01, 2'd1);
    chk("release.busy_cnt", 32'(busy_cnt), 32'd5);

    // mid-stream reset with a result held
    out_ready = 1'b0;
    req_a     = 8'hE7;
    rst_n     = 1'b0;
    #1;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.out_o", 32'(out_o), 32'd0);
    chk("mrst.out_id", 32'(out_id), 32'd0);
    chk("mrst.busy_cnt", 32'(busy_cnt), 32'd0);
    chk("mrst.req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mrst_hold.out_valid", 32'(out_valid), 32'd0);
    chk("mrst_hold.req_ready", 32'(req_ready), 32'd0);
    $display("midreset rdy=%b v=%b o=%b id=%0d busy=%0d", req_ready, out_valid, out_o, out_id, busy_cnt);
    rst_n = 1'b1;
    step("post_rst", 4'b1111, 8'hE7, 8'hFF, 1'b0, 4'b0001, 1'b1, 2'b11, 2'd0);

    // long stall: counter reaches all-ones and stays there
    for (int n = 1; n <= 65540; n++) begin
      @(posedge clk);
      #1;
      if (n == 65534) chk("sat.below", 32'(busy_cnt), 32'h0000FFFE);
      if (n == 65535) chk("sat.reach", 32'(busy_cnt), 32'h0000FFFF);
    end
    chk("sat.hold", 32'(busy_cnt), 32'h0000FFFF);
    chk("sat.out_id", 32'(out_id), 32'd0);
    chk("sat.out_o", 32'(out_o), 32'd3);
    chk("sat.req_ready", 32'(req_ready), 32'd0);
    $display("saturate v=%b o=%b id=%0d busy=%0h", out_valid, out_o, out_id, busy_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
